// File: rtl/btb_assoc.sv
// btb_assoc: parametrised set-associative branch target buffer.
//
// IF performs a same-cycle combinational lookup on lookup_pc; EX writes
// resolved branches back through the upd_* port. Each entry holds a valid
// bit, tag, 16-bit target, a saturating direction counter and an LRU age.
// Replacement is true LRU, kept as an age permutation per set. A
// multi-cycle sequencer clears one set per cycle after inv_req.
//
// Parameters: SETS (power of 2, >= 2), WAYS (power of 2, >= 1),
//             CTR_BITS (>= 1).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   lookup_pc                fetch PC
//   hit, predict_taken,      lookup result; all zero while busy or in reset
//   pred_target, hit_way
//   upd_valid, upd_pc,       resolved branch write-back (dropped while busy)
//   upd_taken, upd_target
//   inv_req, busy            full invalidate request / in-progress flag
// Optional feature macro BTB_PERF_EN adds:
//   upd_pred_taken (in), hit_count (out), mispredict_count (out)
module btb_assoc #(
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int CTR_BITS = 2,
    localparam int IDX     = $clog2(SETS),
    localparam int WW      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   lookup_pc,
    output logic          hit,
    output logic          predict_taken,
    output logic [15:0]   pred_target,
    output logic [WW-1:0] hit_way,
    input  logic          upd_valid,
    input  logic [15:0]   upd_pc,
    input  logic          upd_taken,
    input  logic [15:0]   upd_target,
    input  logic          inv_req,
    output logic          busy
`ifdef BTB_PERF_EN
    ,
    input  logic          upd_pred_taken,
    output logic [15:0]   hit_count,
    output logic [15:0]   mispredict_count
`endif
);

    localparam int TW = 15 - IDX;
    localparam logic [CTR_BITS-1:0] W_T  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] W_NT = W_T - CTR_BITS'(1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state;
    logic [IDX-1:0]       ptr;

    logic                 v_q   [SETS][WAYS];
    logic [TW-1:0]        tag_q [SETS][WAYS];
    logic [15:0]          tgt_q [SETS][WAYS];
    logic [CTR_BITS-1:0]  ctr_q [SETS][WAYS];
    logic [WW-1:0]        age_q [SETS][WAYS];

    // Bit 0 of both PCs is ignored: fetches are word-aligned.
    logic                 unused_pc_bits;
    assign unused_pc_bits = lookup_pc[0] ^ upd_pc[0];

    logic [IDX-1:0] l_idx, u_idx;
    logic [TW-1:0]  l_tag, u_tag;
    assign l_idx = lookup_pc[IDX:1];
    assign l_tag = lookup_pc[15:IDX+1];
    assign u_idx = upd_pc[IDX:1];
    assign u_tag = upd_pc[15:IDX+1];

    // ---------------- lookup (read-only, combinational) ----------------
    logic          l_hit, l_msb;
    logic [WW-1:0] l_way;
    logic [15:0]   l_tgt;

    always_comb begin
        l_hit = 1'b0;
        l_msb = 1'b0;
        l_way = '0;
        l_tgt = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!l_hit && v_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
                l_hit = 1'b1;
                l_msb = ctr_q[l_idx][w][CTR_BITS-1];
                l_way = WW'(w);
                l_tgt = tgt_q[l_idx][w];
            end
        end
    end

    logic blank;
    assign blank         = rst | (state == CLEAR);
    assign hit           = l_hit & ~blank;
    assign predict_taken = l_hit & l_msb & ~blank;
    assign pred_target   = blank ? '0 : l_tgt;
    assign hit_way       = blank ? '0 : l_way;
    assign busy          = (state == CLEAR) & ~rst;

    // ---------------- update-side match and victim selection ----------------
    logic          u_hit, found_inv, accept, do_touch;
    logic [WW-1:0] u_way, victim, touch_way, old_age;

    always_comb begin
        u_hit     = 1'b0;
        u_way     = '0;
        found_inv = 1'b0;
        victim    = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!u_hit && v_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
                u_hit = 1'b1;
                u_way = WW'(w);
            end
            if (!found_inv && !v_q[u_idx][w]) begin
                found_inv = 1'b1;
                victim    = WW'(w);
            end
        end
        // Set full: the oldest way carries age WAYS-1.
        if (!found_inv) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[u_idx][w] == WW'(WAYS - 1)) victim = WW'(w);
            end
        end
        touch_way = u_hit ? u_way : victim;
        old_age   = age_q[u_idx][touch_way];
    end

    assign accept   = upd_valid && (state == IDLE);
    assign do_touch = accept && (u_hit || upd_taken);

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    v_q[s][w]   <= 1'b0;
                    tag_q[s][w] <= '0;
                    tgt_q[s][w] <= '0;
                    ctr_q[s][w] <= W_NT;
                    age_q[s][w] <= WW'(w);
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (u_hit) begin
                            if (upd_taken) begin
                                if (ctr_q[u_idx][u_way] != '1)
                                    ctr_q[u_idx][u_way] <= ctr_q[u_idx][u_way] + CTR_BITS'(1);
                                tgt_q[u_idx][u_way] <= upd_target;
                            end else if (ctr_q[u_idx][u_way] != '0) begin
                                ctr_q[u_idx][u_way] <= ctr_q[u_idx][u_way] - CTR_BITS'(1);
                            end
                        end else if (upd_taken) begin
                            v_q[u_idx][victim]   <= 1'b1;
                            tag_q[u_idx][victim] <= u_tag;
                            tgt_q[u_idx][victim] <= upd_target;
                            ctr_q[u_idx][victim] <= W_T;
                        end
                    end
                    // Touched way becomes MRU; ways younger than it age by one.
                    if (do_touch) begin
                        for (int unsigned w = 0; w < WAYS; w++) begin
                            if (WW'(w) == touch_way)
                                age_q[u_idx][w] <= '0;
                            else if (age_q[u_idx][w] < old_age)
                                age_q[u_idx][w] <= age_q[u_idx][w] + WW'(1);
                        end
                    end
                    if (inv_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    for (int unsigned w = 0; w < WAYS; w++) begin
                        v_q[ptr][w]   <= 1'b0;
                        ctr_q[ptr][w] <= W_NT;
                        age_q[ptr][w] <= WW'(w);
                    end
                    ptr <= ptr + IDX'(1);
                    if (ptr == IDX'(SETS - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BTB_PERF_EN
    // Counters clear on the edge that enters CLEAR; that edge's update is
    // still accepted but the clear takes precedence.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count        <= '0;
            mispredict_count <= '0;
        end else if (state == IDLE && inv_req) begin
            hit_count        <= '0;
            mispredict_count <= '0;
        end else if (accept) begin
            if (u_hit && hit_count != '1)
                hit_count <= hit_count + 16'd1;
            if (upd_pred_taken != upd_taken && mispredict_count != '1)
                mispredict_count <= mispredict_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer for the LC-3b five-stage pipeline. It replaces the fixed BTB with configurable sets, ways and saturating-counter width, true LRU replacement, and a multi-cycle invalidate sequencer. IF performs a same-cycle lookup on the fetch PC. EX writes resolved branches back.

## Interface
Parameters:
- SETS, 8, number of sets; power of 2, at least 2.
- WAYS, 2, associativity; power of 2, at least 1.
- CTR_BITS, 2, width of the per-entry saturating direction counter; at least 1.

Ports (IDX = log2(SETS); WW = max(1, log2(WAYS))):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- lookup_pc  in  16  fetch PC from IF.
- hit  out  1  tag match in the indexed set (combinational).
- predict_taken  out  1  hit AND the hit entry's counter MSB.
- pred_target  out  16  target of the hit entry; 0x0000 on miss.
- hit_way  out  WW  way that hit; 0 on miss.
- upd_valid  in  1  resolved branch from EX this cycle.
- upd_pc  in  16  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- upd_target  in  16  resolved target address.
- inv_req  in  1  start a full invalidate.
- busy  out  1  invalidate in progress.

## Operation
- Address split:
  - index = pc[IDX:1]; bit 0 is ignored because fetches are word-aligned.
  - tag = pc[15:IDX+1].
- Entry fields: valid, tag, target[15:0], ctr[CTR_BITS-1:0], age[WW-1:0].
- Weak values: W_NT = 2^(CTR_BITS-1)-1 and W_T = 2^(CTR_BITS-1).
- Lookup: purely combinational on current state.
  - While busy=1, hit, predict_taken, pred_target and hit_way are all 0.
  - Lookups never modify any state, including LRU.
- An update is accepted when upd_valid=1 and busy=0. Updates arriving while busy=1 are dropped.
- Accepted update, tag match in the set:
  - ctr increments on taken, saturating at 2^CTR_BITS-1.
  - ctr decrements on not-taken, saturating at 0.
  - On taken, target is overwritten with upd_target.
  - The matched way becomes MRU.
- Accepted update, miss, upd_taken=1: allocate one way.
  - Victim is the lowest-index invalid way; if every way is valid, the way with age = WAYS-1.
  - Write valid=1, tag, target = upd_target, ctr = W_T.
  - The allocated way becomes MRU.
- Accepted update, miss, upd_taken=0: no state change.
- LRU (age permutation per set):
  - The touched way's age goes to 0.
  - Every way whose age was less than the touched way's old age increments by 1.
  - All other ways are unchanged.
- Invalidate FSM, states IDLE and CLEAR:
  - IDLE to CLEAR when inv_req=1; the clear pointer is set to 0.
  - In CLEAR, each cycle the set at the pointer is written: valid=0, ctr=W_NT, age[w]=w. The pointer then increments.
  - CLEAR to IDLE after set SETS-1 is written.
  - inv_req is ignored while in CLEAR.
- Reset, including reset in the middle of CLEAR: every set gets valid=0, ctr=W_NT, age[w]=w, target=0. The FSM goes to IDLE and busy=0.
- Output values while rst is held: hit=0, predict_taken=0, pred_target=0, hit_way=0, busy=0.

## Timing
- Lookup latency is 0 cycles (combinational from lookup_pc).
- An accepted update is visible to lookup in the cycle after the edge that samples it.
- Lookup and update in the same cycle, same set: the lookup returns pre-update contents (read-before-write).
- busy rises the cycle after inv_req is sampled and stays high for exactly SETS cycles.
- A new lookup hit is possible in the first cycle after busy falls.

## Configuration
- `BTB_PERF_EN` defined:
  - Adds input upd_pred_taken (1) and outputs hit_count (16) and mispredict_count (16).
  - hit_count increments on each accepted update that tag-matches.
  - mispredict_count increments on each accepted update where upd_pred_taken != upd_taken.
  - Both counters saturate at 0xFFFF.
  - Both counters clear on rst and in the cycle CLEAR is entered.
- `BTB_PERF_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
Parameters for all scenarios: SETS=8, WAYS=2, CTR_BITS=2.
- Reset, then lookup_pc=0x3000 -> hit=0, predict_taken=0, pred_target=0x0000, busy=0.
- Update 0x3004, taken, target 0x3100, with lookup_pc=0x3004 in the same cycle:
  - Same cycle -> hit=0.
  - Next cycle -> hit=1, predict_taken=1 (ctr=2), pred_target=0x3100.
- Then three not-taken updates of 0x3004:
  - After the first -> ctr=1, hit=1, predict_taken=0.
  - After the third -> ctr=0 (saturated), entry still valid.
- Taken updates in order 0x3004, 0x3104, 0x3004, 0x3204 (all set 2):
  - 0x3204 evicts 0x3104.
  - Lookups then give 0x3104 -> hit=0; 0x3004 -> hit=1; 0x3204 -> hit=1.
- Fill set 2, then pulse inv_req for one cycle, with an update of 0x3008 issued during busy:
  - busy=1 for exactly 8 cycles.
  - Afterwards 0x3004 and 0x3008 both miss; the 0x3008 update was dropped.
- With `BTB_PERF_EN`: three accepted updates of 0x3004 giving (pred, actual) = (0,1), (1,1), (1,0) -> hit_count=2, mispredict_count=2. Pulsing inv_req then clears both to 0.
